// File: rtl/decode_issue.sv
// decode_issue: consumer end of the fetch interface. Decodes a two-slot
// 64-bit bundle, checks RAW hazards against a load-latency scoreboard,
// splits bundles when slot B depends on slot A, and drives interlock and
// the direct-jump redirect back to fetch in the same cycle.
// Optional feature: define DECODE_STALL_STATS_EN to add the stall_count output.
module decode_issue #(
    parameter logic [5:0]  OP_NOP   = 6'd0,
    parameter logic [5:0]  OP_JUMP  = 6'd2,
    parameter logic [5:0]  OP_LOAD  = 6'd35,
    parameter int unsigned LOAD_LAT = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] pc_in,
    input  logic [63:0] inst_in,
    input  logic        flush,
    output logic        interlock,
    output logic        branch_flag,
    output logic [31:0] branch_pc,
    output logic [31:0] issue_pc,
`ifdef DECODE_STALL_STATS_EN
    output logic [31:0] stall_count,
`endif
    output logic [63:0] issue_inst
);

    localparam int unsigned NREG       = 32;
    localparam logic [31:0] NOP_SLOT   = {OP_NOP, 26'b0};
    localparam logic [63:0] NOP_BUNDLE = {NOP_SLOT, NOP_SLOT};
    localparam logic [1:0]  LOAD_INIT  = 2'(LOAD_LAT - 1);

    typedef enum logic {RUN, SPLIT} state_t;

    state_t      state, state_nxt;
    logic [1:0]  cnt     [NREG];
    logic [1:0]  cnt_nxt [NREG];
    logic [31:0] busy;
    logic [63:0] issue_nxt;
    logic [31:0] pc_nxt;
    logic        interlock_int, branch_int;
    logic [31:0] branch_pc_int;
    logic        haz_a, haz_b;

    logic [31:0] slot_a, slot_b;
    assign slot_a = inst_in[63:32];
    assign slot_b = inst_in[31:0];

    // Slots other than no-op and jump read rs/rt and write rd.
    function automatic logic is_writer(input logic [31:0] s);
        return (s[31:26] != OP_NOP) && (s[31:26] != OP_JUMP);
    endfunction

    function automatic logic reads_busy(input logic [31:0] s, input logic [31:0] b);
        return is_writer(s) && (b[s[20:16]] || b[s[15:11]]);
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] s);
        return {6'b0, s[25:0]};
    endfunction

    // Busy vector from the scoreboard; register 0 is never busy.
    always_comb begin
        busy = '0;
        for (int i = 1; i < NREG; i++) busy[i] = (cnt[i] != 2'd0);
    end

    // Hazard detection for both slots, including the intra-bundle A->B dependency.
    always_comb begin
        haz_a = reads_busy(slot_a, busy);
        haz_b = reads_busy(slot_b, busy)
              || (is_writer(slot_a) && is_writer(slot_b) && (slot_a[25:21] != 5'd0)
                  && ((slot_b[20:16] == slot_a[25:21]) || (slot_b[15:11] == slot_a[25:21])));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) state <= RUN;
        else       state <= state_nxt;
    end

    // Next-state and issue/redirect decisions.
    always_comb begin
        state_nxt     = state;
        interlock_int = 1'b0;
        branch_int    = 1'b0;
        branch_pc_int = '0;
        issue_nxt     = NOP_BUNDLE;
        pc_nxt        = '0;
        case (state)
            RUN: begin
                if (flush) begin
                    state_nxt = RUN;
                end else if (haz_a) begin
                    interlock_int = 1'b1;
                end else if (slot_a[31:26] == OP_JUMP) begin
                    branch_int    = 1'b1;
                    branch_pc_int = jump_target(slot_a);
                end else if (haz_b) begin
                    issue_nxt     = {slot_a, NOP_SLOT};
                    pc_nxt        = pc_in;
                    interlock_int = 1'b1;
                    state_nxt     = SPLIT;
                end else if (slot_b[31:26] == OP_JUMP) begin
                    issue_nxt     = {slot_a, NOP_SLOT};
                    pc_nxt        = pc_in;
                    branch_int    = 1'b1;
                    branch_pc_int = jump_target(slot_b);
                end else begin
                    issue_nxt = inst_in;
                    pc_nxt    = pc_in;
                end
            end
            SPLIT: begin
                if (flush) begin
                    state_nxt = RUN;
                end else if (reads_busy(slot_b, busy)) begin
                    interlock_int = 1'b1;
                end else if (slot_b[31:26] == OP_JUMP) begin
                    branch_int    = 1'b1;
                    branch_pc_int = jump_target(slot_b);
                    state_nxt     = RUN;
                end else begin
                    issue_nxt = {NOP_SLOT, slot_b};
                    pc_nxt    = pc_in;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    assign interlock   = rstn & interlock_int;
    assign branch_flag = rstn & branch_int;
    assign branch_pc   = rstn ? branch_pc_int : 32'd0;

    // Scoreboard next value: age every counter, then apply writes from issued slots.
    always_comb begin
        for (int i = 0; i < NREG; i++)
            cnt_nxt[i] = (cnt[i] != 2'd0) ? cnt[i] - 2'd1 : 2'd0;
        if (is_writer(issue_nxt[63:32]) && (issue_nxt[57:53] != 5'd0))
            cnt_nxt[issue_nxt[57:53]] = (issue_nxt[63:58] == OP_LOAD) ? LOAD_INIT : 2'd0;
        if (is_writer(issue_nxt[31:0]) && (issue_nxt[25:21] != 5'd0))
            cnt_nxt[issue_nxt[25:21]] = (issue_nxt[31:26] == OP_LOAD) ? LOAD_INIT : 2'd0;
    end

    // Issue registers and scoreboard.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            issue_inst <= NOP_BUNDLE;
            issue_pc   <= '0;
            for (int i = 0; i < NREG; i++) cnt[i] <= 2'd0;
        end else begin
            issue_inst <= issue_nxt;
            issue_pc   <= pc_nxt;
            for (int i = 0; i < NREG; i++) cnt[i] <= cnt_nxt[i];
        end
    end

`ifdef DECODE_STALL_STATS_EN
    // Count interlocked cycles; wraps naturally.
    always_ff @(posedge clk) begin
        if (!rstn)          stall_count <= '0;
        else if (interlock) stall_count <= stall_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_decode_issue.sv
// Directed self-checking bench for decode_issue (LOAD_LAT = 3).
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] pc_in;
    logic [63:0] inst_in;
    logic        flush;
    logic        interlock, branch_flag;
    logic [31:0] branch_pc, issue_pc;
    logic [63:0] issue_inst;
`ifdef DECODE_STALL_STATS_EN
    logic [31:0] stall_count;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] NOP = 32'h0;
    localparam logic [63:0] NOPB = 64'h0;

    decode_issue dut (
        .clk        (clk),
        .rstn       (rstn),
        .pc_in      (pc_in),
        .inst_in    (inst_in),
        .flush      (flush),
        .interlock  (interlock),
        .branch_flag(branch_flag),
        .branch_pc  (branch_pc),
        .issue_pc   (issue_pc),
`ifdef DECODE_STALL_STATS_EN
        .stall_count(stall_count),
`endif
        .issue_inst (issue_inst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
        return {op, rd, rs, rt, 11'b0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] add1, add4, ld5, add6, add7, sub8, jmp, add9, add10, add11, add12, jmpb;

    initial begin
        add1  = mk(6'd32, 5'd1, 5'd2, 5'd3);
        add4  = mk(6'd32, 5'd4, 5'd5, 5'd6);
        ld5   = mk(6'd35, 5'd5, 5'd0, 5'd0);
        add6  = mk(6'd32, 5'd6, 5'd5, 5'd0);
        add7  = mk(6'd32, 5'd7, 5'd1, 5'd2);
        sub8  = mk(6'd34, 5'd8, 5'd7, 5'd3);
        jmp   = {6'd2, 26'h0000123};
        add9  = mk(6'd32, 5'd9, 5'd1, 5'd1);
        add10 = mk(6'd32, 5'd10, 5'd1, 5'd2);
        add11 = mk(6'd32, 5'd11, 5'd1, 5'd2);
        add12 = mk(6'd32, 5'd12, 5'd1, 5'd2);
        jmpb  = {6'd2, 26'h0000456};

        // Reset; jump presented to prove comb outputs are gated.
        rstn = 1'b0; flush = 1'b0; pc_in = 32'h0; inst_in = {jmp, NOP};
        #1;
        chk("rst_branch_flag", 64'(branch_flag), 64'd0);
        chk("rst_branch_pc",   64'(branch_pc),   64'd0);
        tick(); tick();
        chk("rst_issue_inst", issue_inst, NOPB);
        chk("rst_issue_pc",   64'(issue_pc), 64'd0);
`ifdef DECODE_STALL_STATS_EN
        chk("rst_stall_count", 64'(stall_count), 64'd0);
`endif
        rstn = 1'b1; inst_in = NOPB;

        // Scenario 1: independent pair issues whole.
        inst_in = {add1, add4}; pc_in = 32'h10;
        #0;
        chk("s1_interlock", 64'(interlock), 64'd0);
        tick();
        chk("s1_issue_inst", issue_inst, {add1, add4});
        chk("s1_issue_pc",   64'(issue_pc), 64'h10);

        // Scenario 2: load-use stall for two cycles.
        inst_in = {ld5, NOP}; pc_in = 32'h20;
        #0;
        chk("s2_ld_interlock", 64'(interlock), 64'd0);
        tick();
        chk("s2_ld_issue", issue_inst, {ld5, NOP});
        inst_in = {add6, NOP}; pc_in = 32'h24;
        #0;
        chk("s2_stall1_interlock", 64'(interlock), 64'd1);
        tick();
        chk("s2_stall1_issue", issue_inst, NOPB);
        chk("s2_stall1_pc",    64'(issue_pc), 64'd0);
        chk("s2_stall2_interlock", 64'(interlock), 64'd1);
        tick();
        chk("s2_stall2_issue", issue_inst, NOPB);
        chk("s2_free_interlock", 64'(interlock), 64'd0);
        tick();
        chk("s2_add_issue", issue_inst, {add6, NOP});
        chk("s2_add_pc",    64'(issue_pc), 64'h24);
`ifdef DECODE_STALL_STATS_EN
        chk("s2_stall_count", 64'(stall_count), 64'd2);
`endif

        // Scenario 3: intra-bundle dependency splits the bundle.
        inst_in = {add7, sub8}; pc_in = 32'h30;
        #0;
        chk("s3_run_interlock", 64'(interlock), 64'd1);
        tick();
        chk("s3_a_issue", issue_inst, {add7, NOP});
        chk("s3_a_pc",    64'(issue_pc), 64'h30);
        chk("s3_split_interlock", 64'(interlock), 64'd0);
        tick();
        chk("s3_b_issue", issue_inst, {NOP, sub8});
        chk("s3_b_pc",    64'(issue_pc), 64'h30);

        // Scenario 4: jump in slot A squashes slot B.
        inst_in = {jmp, add9}; pc_in = 32'h50;
        #0;
        chk("s4_branch_flag", 64'(branch_flag), 64'd1);
        chk("s4_branch_pc",   64'(branch_pc), 64'h123);
        chk("s4_interlock",   64'(interlock), 64'd0);
        tick();
        chk("s4_issue", issue_inst, NOPB);
        chk("s4_pc",    64'(issue_pc), 64'd0);
        inst_in = NOPB; pc_in = 32'h123;
        #0;
        chk("s4_pulse_end", 64'(branch_flag), 64'd0);
        tick();

        // Scenario 5: flush in SPLIT drops slot B.
        inst_in = {add7, sub8}; pc_in = 32'h60;
        tick();
        chk("s5_a_issue", issue_inst, {add7, NOP});
        flush = 1'b1;
        #0;
        chk("s5_flush_interlock", 64'(interlock), 64'd0);
        tick();
        chk("s5_flush_issue", issue_inst, NOPB);
        chk("s5_flush_pc",    64'(issue_pc), 64'd0);
        flush = 1'b0; inst_in = {add10, add11}; pc_in = 32'h70;
        tick();
        chk("s5_run_issue", issue_inst, {add10, add11});

        // Jump in slot B: A issues, redirect to B's target.
        inst_in = {add12, jmpb}; pc_in = 32'h80;
        #0;
        chk("jb_branch_flag", 64'(branch_flag), 64'd1);
        chk("jb_branch_pc",   64'(branch_pc), 64'h456);
        tick();
        chk("jb_issue", issue_inst, {add12, NOP});
        chk("jb_pc",    64'(issue_pc), 64'h80);

        // Reset during SPLIT drops pending slot B.
        inst_in = {add7, sub8}; pc_in = 32'h90;
        tick();
        chk("rs_a_issue", issue_inst, {add7, NOP});
        rstn = 1'b0;
        #0;
        chk("rs_interlock_gated", 64'(interlock), 64'd0);
        tick();
        chk("rs_issue", issue_inst, NOPB);
`ifdef DECODE_STALL_STATS_EN
        chk("rs_stall_count", 64'(stall_count), 64'd0);
`endif
        rstn = 1'b1; inst_in = NOPB; pc_in = 32'h0;
        tick();
        chk("rs_b_dropped", issue_inst, NOPB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- Consumer end of the fetch interface.
- Takes each 64-bit two-slot bundle plus its bundle PC, and checks RAW hazards against a load-latency scoreboard.
- Issues slots to exec, splitting a bundle when slot B depends on slot A.
- Drives interlock and the direct-jump redirect (branch_flag/branch_pc) back to fetch, combinationally in the same cycle. Sits between fetch and exec.

Parameters:
- OP_NOP, 6'd0, opcode of a no-op slot; a Nop bundle is {OP_NOP,26'b0,OP_NOP,26'b0}.
- OP_JUMP, 6'd2, direct jump opcode; target = zero-extended inst[25:0] as bundle address.
- OP_LOAD, 6'd35, load opcode; result available LOAD_LAT cycles after issue.
- LOAD_LAT, 3, load latency, legal 1..4.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- pc_in  in  32  bundle PC from fetch.
- inst_in  in  64  bundle from fetch; slot A = [63:32], slot B = [31:0]. Held stable by fetch while interlock=1.
- flush  in  1  exec redirect; discard the current bundle and any split state.
- interlock  out  1  combinational; fetch holds its bundle.
- branch_flag  out  1  combinational; redirect fetch this cycle.
- branch_pc  out  32  combinational jump target.
- issue_pc  out  32  registered PC of the issued bundle.
- issue_inst  out  64  registered issued bundle; unissued slots are Nop.

Behaviour:
- Reset: issue_inst = Nop bundle, issue_pc = 0, state = RUN, all scoreboard counters = 0.
- Combinational outputs are 0 while rstn=0.
- Fields: op[31:26], rd[25:21], rs[20:16], rt[15:11].
- Every slot whose opcode is neither OP_NOP nor OP_JUMP reads rs and rt and writes rd. Register 0 is never busy.
- Scoreboard: 32 counters, 2 bits each.
  - Issuing OP_LOAD sets cnt[rd] = LOAD_LAT-1. Issuing any other writer clears cnt[rd] (exec forwards).
  - Each cycle every nonzero counter not being written that cycle decrements by 1.
  - A source is busy when its counter != 0.
- Hazards:
  - hazA: slot A reads a busy register.
  - hazB: slot B reads a busy register, or reads slot A's nonzero rd.
- State RUN:
  - flush: issue Nop bundle; interlock = 0, branch_flag = 0.
  - Else hazA: issue Nop bundle, interlock = 1.
  - Else A is OP_JUMP: issue {Nop,Nop}; branch_flag = 1, branch_pc = target; slot B is squashed.
  - Else hazB: issue {A,Nop}, interlock = 1, go to SPLIT.
  - Else B is OP_JUMP: issue {A,Nop}; branch_flag = 1.
  - Else: issue {A,B}.
- State SPLIT (slot A already issued):
  - flush: go to RUN, issue Nop bundle.
  - Else B reads a busy register: issue Nop bundle, interlock = 1.
  - Else B is OP_JUMP: issue Nop bundle; branch_flag = 1, return to RUN.
  - Else: issue {Nop,B}, return to RUN.
- issue_pc = pc_in whenever any slot is issued, else 0.
- branch_flag is never asserted together with interlock. Each branch_flag is a single-cycle pulse.
- Scoreboard updates use the issued slots only. A hazard check in cycle N sees updates from cycles up to N-1.
- Reset asserted mid-SPLIT: the pending slot B is dropped.

Optional Feature:
- Macro DECODE_STALL_STATS_EN.
- When defined: extra output stall_count[31:0], reset 0. It increments every cycle interlock=1 and wraps from 2^32-1 to 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then bundle {add r1,r2,r3 ; add r4,r5,r6} at pc 0x10 -> next cycle issue_inst = same bundle, issue_pc = 0x10; interlock = 0 throughout.
- Bundle {load r5 ; Nop}, then {add r6,r5,r0 ; Nop}, LOAD_LAT=3 -> interlock high 2 cycles with Nop issued; add issues on the 3rd cycle.
- Bundle {add r7,r1,r2 ; sub r8,r7,r3} -> cycle 1: issue {add,Nop}, interlock = 1. Cycle 2: issue {Nop,sub}, interlock = 0, back to RUN.
- Bundle {Jump 0x0000123 ; add r9,r1,r1} -> branch_flag = 1 for one cycle, branch_pc = 0x00000123; issue_inst = Nop bundle; add never issued.
- Split bundle as in scenario 3, with flush asserted in the SPLIT cycle -> Nop bundle issued, state RUN, slot B never issued.
- DECODE_STALL_STATS_EN defined, scenario 2 -> stall_count = 2 afterwards; reset mid-run -> stall_count = 0.
